// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing for the Pong display.
//
// A clk-domain pixel-enable divider (CLK_DIV clk per pixel) advances a
// horizontal/vertical position counter pair. Sync, blanking and the strobes
// are decoded from the *next* position and registered with it, so every
// output changes on the same clk edge as hcount/vcount.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous reset, active-low
//   hcount       out  [9:0] pixel column, 0..H_TOTAL-1
//   vcount       out  [9:0] line, 0..V_TOTAL-1
//   hsync/vsync  out  sync pulses, asserted level = SYNC_POL
//   video_on     out  position lies inside the visible area
//   pix_en       out  1-clk strobe on the first clk of each pixel position
//   line_start   out  1-clk strobe when hcount becomes 0
//   frame_start  out  1-clk strobe when (hcount,vcount) becomes (0,0)
//   frame_count  out  [7:0] frames started since reset, wraps
//
// Counters are 10 bits wide: H_TOTAL and V_TOTAL must not exceed 1024.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;   // exclusive
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;   // exclusive
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          h_wrap, v_wrap;
  logic [9:0]    h_nxt, v_nxt;
  logic          hs_nxt, vs_nxt, von_nxt;

  // With CLK_DIV=1 the divider sits at 0 and tick is permanently high.
  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  // Next raster position; only committed on a tick edge.
  always_comb begin
    h_wrap  = (hcount == 10'(H_TOTAL - 1));
    v_wrap  = (vcount == 10'(V_TOTAL - 1));
    h_nxt   = h_wrap ? 10'd0 : hcount + 10'd1;
    v_nxt   = vcount;
    if (h_wrap)
      v_nxt = v_wrap ? 10'd0 : vcount + 10'd1;
    // 11-bit compares so an end bound of exactly 1024 still works.
    hs_nxt  = ({1'b0, h_nxt} >= 11'(HS_START)) && ({1'b0, h_nxt} < 11'(HS_END));
    vs_nxt  = ({1'b0, v_nxt} >= 11'(VS_START)) && ({1'b0, v_nxt} < 11'(VS_END));
    von_nxt = ({1'b0, h_nxt} < 11'(H_ACTIVE)) && ({1'b0, v_nxt} < 11'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Park on the last position so the first tick lands on (0,0).
      div_cnt     <= '0;
      hcount      <= 10'(H_TOTAL - 1);
      vcount      <= 10'(V_TOTAL - 1);
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DW'(1);
      pix_en      <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        hcount   <= h_nxt;
        vcount   <= v_nxt;
        hsync    <= hs_nxt ? SYNC_POL : ~SYNC_POL;
        vsync    <= vs_nxt ? SYNC_POL : ~SYNC_POL;
        video_on <= von_nxt;
        if (h_wrap && v_wrap)
          frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks two builds of vga_timing_gen against an
// arithmetic raster model evaluated every clk.
//   dut_a : default 640x480 timing, CLK_DIV=2, active-low sync
//   dut_b : tiny 15x8 raster, CLK_DIV=1, active-high sync (fast frame wrap)
// The model derives every output from n = clk edges since reset release:
// ticks = n/CLK_DIV, position index = ticks-1, split with div/mod.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs, vs, von, pe, ls, fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [9:0] hcount_a, vcount_a, hcount_b, vcount_b;
  logic hsync_a, vsync_a, video_on_a, pix_en_a, line_start_a, frame_start_a;
  logic hsync_b, vsync_b, video_on_b, pix_en_b, line_start_b, frame_start_b;
  logic [7:0] frame_count_a, frame_count_b;

  int checks = 0;
  int errors = 0;
  int prints = 0;
  int na = 0, nb = 0;
  bit chk_on = 1'b0;
  int fs_b = 0, vs_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .hcount(hcount_a), .vcount(vcount_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .pix_en(pix_en_a),
    .line_start(line_start_a), .frame_start(frame_start_a), .frame_count(frame_count_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .pix_en(pix_en_b),
    .line_start(line_start_b), .frame_start(frame_start_b), .frame_count(frame_count_b)
  );

  // Edges since the last sampled reset.
  always @(posedge clk) begin
    na <= rst_a ? na + 1 : 0;
    nb <= rst_b ? nb + 1 : 0;
  end

  function automatic obs_t model(int n, int div, int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp, bit pol);
    obs_t o;
    int ht, vt, p, k, h, v;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p  = n / div;
    if (p == 0) begin
      o.h = 10'(ht - 1); o.v = 10'(vt - 1);
      o.hs = !pol; o.vs = !pol; o.von = 1'b0;
      o.pe = 1'b0; o.ls = 1'b0; o.fs = 1'b0; o.fc = 8'd0;
    end else begin
      k = p - 1;
      h = k % ht;
      v = (k / ht) % vt;
      o.h   = 10'(h);
      o.v   = 10'(v);
      o.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : !pol;
      o.vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : !pol;
      o.von = (h < ha) && (v < va);
      o.pe  = (n % div) == 0;
      o.ls  = o.pe && (h == 0);
      o.fs  = o.pe && (h == 0) && (v == 0);
      o.fc  = 8'(((k / (ht * vt)) + 1) % 256);
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 30) begin
        prints++;
        $display("FAIL %s actual h=%0d v=%0d hs=%b vs=%b von=%b pe=%b ls=%b fs=%b fc=%0d expected h=%0d v=%0d hs=%b vs=%b von=%b pe=%b ls=%b fs=%b fc=%0d at %0t",
                 name, act.h, act.v, act.hs, act.vs, act.von, act.pe, act.ls, act.fs, act.fc,
                 exp.h, exp.v, exp.hs, exp.vs, exp.von, exp.pe, exp.ls, exp.fs, exp.fc, $time);
      end
    end
  endtask

  // Per-cycle model comparison for both builds.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_a",
          {hcount_a, vcount_a, hsync_a, vsync_a, video_on_a, pix_en_a, line_start_a, frame_start_a, frame_count_a},
          model(na, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      cmp("model_b",
          {hcount_b, vcount_b, hsync_b, vsync_b, video_on_b, pix_en_b, line_start_b, frame_start_b, frame_count_b},
          model(nb, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1));
      // Small build: vsync width per frame and frame_count wrap, hand values.
      if (frame_start_b) begin
        fs_b++;
        if (fs_b == 2)   chk("b_vsync_clks_per_frame", vs_cnt, 30);
        if (fs_b == 256) chk("b_frame_count_wrap", int'(frame_count_b), 0);
        vs_cnt = 0;
      end
      if (vsync_b) vs_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, von_cnt, pe_cnt;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    chk_on = 1'b1;

    // Reset state, literal values.
    chk("rst_hcount", int'(hcount_a), 799);
    chk("rst_vcount", int'(vcount_a), 524);
    chk("rst_syncs", int'({hsync_a, vsync_a}), 3);
    chk("rst_flags", int'({video_on_a, pix_en_a, line_start_a, frame_start_a}), 0);
    chk("rst_frame_count", int'(frame_count_a), 0);
    chk("rst_b_syncs_deasserted", int'({hsync_b, vsync_b}), 0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("first_clk_no_tick", int'({pix_en_a, hcount_a}), 799);
    chk("b_first_clk_origin", int'({pix_en_b, frame_start_b, hcount_b, vcount_b}), 'h3 << 20);
    @(negedge clk);
    chk("origin_hv", int'({hcount_a, vcount_a}), 0);
    chk("origin_strobes", int'({pix_en_a, line_start_a, frame_start_a, video_on_a}), 'hf);
    chk("origin_frame_count", int'(frame_count_a), 1);

    // One full line: 800 pixels x 2 clk.
    hs_low = 0; von_cnt = 0; pe_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      if (!hsync_a)  hs_low++;
      if (video_on_a) von_cnt++;
      if (pix_en_a)  pe_cnt++;
      @(negedge clk);
    end
    chk("line_hsync_low_clks", hs_low, 192);
    chk("line_video_on_clks", von_cnt, 1280);
    chk("line_pix_en_count", pe_cnt, 800);
    chk("wrap_hv", int'({hcount_a, vcount_a}), 1);
    chk("wrap_strobes", int'({line_start_a, frame_start_a}), 2);

    // Mid-raster reset at (300,2).
    for (int i = 0; i < 6000 && !(hcount_a == 10'd300 && vcount_a == 10'd2); i++)
      @(negedge clk);
    chk("reached_300_2", int'({hcount_a, vcount_a}), (300 << 10) | 2);
    rst_a = 1'b0;
    @(negedge clk);
    chk("midrst_hcount", int'(hcount_a), 799);
    chk("midrst_vcount", int'(vcount_a), 524);
    chk("midrst_frame_count", int'(frame_count_a), 0);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("resume_origin", int'({hcount_a, vcount_a, frame_start_a}), 1);
    chk("resume_frame_count", int'(frame_count_a), 1);

    repeat (36000) @(negedge clk);
    chk("b_wrap_reached", int'(fs_b > 256), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
